// File: rtl/udp_writer_if.sv
// udp_writer_if: application/engine-facing signals of udp_writer
interface udp_writer_if #(
  parameter int CAPACITY = 6
);
  logic                  send;
  logic [CAPACITY*8-1:0] i_data;
  logic                  trig;
  logic                  read_en;
  logic [7:0]            o_data;
  logic [15:0]           data_len;
  logic                  busy;
  logic                  done;
  logic                  error;
  modport master (
    output send, i_data, read_en,
    input  trig, o_data, data_len, busy, done, error
  );
  modport slave (
    input  send, i_data, read_en,
    output trig, o_data, data_len, busy, done, error
  );
endinterface

// File: rtl/udp_writer.sv
// udp_writer: snapshots a CAPACITY-byte payload and streams it MSB-first into udp_packet's TX path
module udp_writer #(
  parameter int CAPACITY = 6,
  parameter int TIMEOUT  = 1_000_000
) (
  input logic         clk,
  input logic         rstn,
  udp_writer_if.slave bus
);
  localparam int PW = $clog2(CAPACITY + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;
  state_t                state, state_n;
  logic [PW-1:0]         ptr;
  logic [CW-1:0]         ctr;
  logic [CAPACITY*8-1:0] shadow;
  logic [7:0]            cur;
  logic                  idle, accept, rd, last, tmo;
  logic                  trig_n, busy_n, done_n, err_n;
  assign idle          = state == IDLE;
  assign accept        = idle && bus.send;
  assign rd            = bus.read_en && !idle;
  assign last          = ptr == PW'(CAPACITY - 1);
  // a read in the same cycle as the timeout wins, so tmo requires !read_en
  assign tmo           = state == REQ && !bus.read_en && ctr == CW'(TIMEOUT - 1);
  assign bus.data_len  = 16'(CAPACITY);
  always_comb begin
    cur = '0;
    for (int k = 0; k < CAPACITY; k++)
      if (ptr == PW'(k)) cur = shadow[(CAPACITY-k)*8-1 -: 8];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= IDLE;
      bus.trig  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      state     <= state_n;
      bus.trig  <= trig_n;
      bus.busy  <= busy_n;
      bus.done  <= done_n;
      bus.error <= err_n;
    end
  always_comb
    state_n = idle ? (bus.send ? REQ : IDLE) :
              rd   ? (last ? IDLE : SEND)    :
              tmo  ? IDLE : state;
  always_comb begin
    trig_n = state_n == REQ;
    busy_n = state_n != IDLE;
    done_n = rd && last;
    err_n  = (idle ? bus.read_en : bus.send) || tmo;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      shadow     <= '0;
      ptr        <= '0;
      ctr        <= '0;
      bus.o_data <= 8'h00;
    end else begin
      if (accept) begin
        shadow <= bus.i_data;
        ptr    <= '0;
        ctr    <= '0;
      end else if (state == REQ) begin
        ctr <= ctr + CW'(1);
      end
      if (idle && bus.read_en) begin
        bus.o_data <= 8'h00;
      end else if (rd) begin
        bus.o_data <= cur;
        ptr        <= ptr + PW'(1);
      end
    end
endmodule

// File: doc/udp_writer.md
# udp_writer

Transmit-side counterpart of the UDP receive buffer: it snapshots a parallel payload of `CAPACITY` bytes and serializes it byte-by-byte into the UDP packet engine's TX data path. The block runs in the `rgmii_clk` domain between the application (box results, status words) and `udp_packet`. On the engine side it drives `trig` and answers `tx_read_en` with `tx_data`. Bytes go out MSB-first, matching the receive buffer's byte order, so a buffer sent by one board is reproduced bit-exact in `udp_reader.o_data` on the other.

## Interface
Parameters:
- `CAPACITY`, default 6: payload bytes per packet; legal range 1..1472.
- `TIMEOUT`, default 1_000_000: cycles to wait in REQ for the first `read_en` before aborting.

Ports:
- `clk`  in  1  — `rgmii_clk` domain clock.
- `rstn`  in  1  — one clock; reset is asynchronous and active-low.
- `send`  in  1  — single-cycle request; captures `i_data` when accepted.
- `i_data`  in  CAPACITY*8  — payload; byte k is `i_data[(CAPACITY-k)*8-1 -: 8]`.
- `trig`  out  1  — packet request to `udp_packet.trig`.
- `read_en`  in  1  — byte read strobe from `udp_packet.tx_read_en`.
- `o_data`  out  8  — byte to `udp_packet.tx_data`.
- `data_len`  out  16  — constant `CAPACITY`, to `tx_data_len`.
- `busy`  out  1  — high in REQ or SEND.
- `done`  out  1  — one-cycle pulse when the last byte has been read.
- `error`  out  1  — one-cycle pulse on timeout, overread, or dropped `send`.

## Operation
- **Reset values:** state=IDLE, `trig`=0, `o_data`=0, `busy`=0, `done`=0, `error`=0, pointer=0, shadow=0, timeout counter=0. `data_len` is a constant.
- **IDLE**
  - `send`=1: shadow ← `i_data`, ptr ← 0, ctr ← 0, go to REQ.
  - `read_en` in IDLE: `o_data` ← 0, and `error` pulses.
- **REQ**
  - `trig`=1 (registered).
  - ctr increments each cycle. When ctr reaches `TIMEOUT`-1 with no `read_en`: go to IDLE and pulse `error`.
  - On the first `read_en`: serve byte 0 (see SEND rule) and go to SEND.
- **SEND**
  - `trig`=0.
  - Each cycle `read_en`=1: `o_data` ← shadow byte[ptr], ptr ← ptr+1.
  - The read where ptr = `CAPACITY`-1: next state IDLE, `done` pulses the following cycle.
  - Gaps in `read_en` are allowed; `o_data` holds its value during gaps.
- **Pointer width:** `$clog2(CAPACITY+1)` bits. The pointer never wraps; the last read returns the block to IDLE.
- **Overread:** a `read_en` in IDLE after `done` yields `o_data`=0 plus an `error` pulse. Shadow and pointer are unchanged.
- **Dropped request:** `send` while `busy` is ignored and pulses `error`. The shadow is not modified mid-packet.
- **Simultaneous events:**
  - `send` in the same cycle as the final read: the request is dropped with an `error` pulse, because the block is still busy that cycle.
  - Timeout and `read_en` in the same cycle: `read_en` wins; the byte is served and the block goes to SEND.
- **Reset mid-packet:** everything clears asynchronously. `trig` falls immediately; no `done` is issued.

## Timing
- `send` at cycle 0 → `trig`=1 and `busy`=1 from cycle 1.
- `read_en` at cycle n → `o_data` valid at n+1. This is FIFO read latency 1, which is what `udp_packet` expects.
- First `read_en` at cycle n → `trig` low from n+1.
- Final `read_en` at cycle m → `busy`=0 and `done`=1 at m+1. A new `send` is accepted from m+1.
- Best-case packet: 1 + `CAPACITY` cycles of `read_en` plus 1 cycle for `done`.
- `busy` and `done` are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic send:** `CAPACITY`=6, `i_data`=48'h0102_0304_0506, `send`, then 6 back-to-back `read_en` → `o_data` = 01,02,03,04,05,06 on cycles n+1..n+6, `done` at n+6, `trig` high only until n+1.
- **Gapped reads:** same stimulus with `read_en` every third cycle → `o_data` holds during gaps, same byte order, a single `done`.
- **Timeout:** `TIMEOUT`=16, `send`, no `read_en` → `error` pulse at cycle 17, `trig`=0, `busy`=0; a subsequent `send` works normally.
- **Busy drop:** second `send` with `i_data`=48'hFFFF_FFFF_FFFF issued mid-packet → one `error` pulse; the remaining bytes still come from the original payload.
- **Overread:** a 7th `read_en` after `done` → `o_data`=00 and one `error` pulse.
- **Reset mid-packet:** assert `rstn`=0 after 3 bytes → all outputs 0 immediately; after release, a fresh packet starts at byte 0.
